// File: rtl/nibble_bus_pkg.sv
// Shared nibble-bus cycle codes and loader state encoding.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package nibble_bus_pkg;

    // Full cycle codes on cpu_bus[7:4]
    localparam logic [3:0] CODE_LOAD  = 4'b0111;
    localparam logic [3:0] CODE_STORE = 4'b0011;

    // Phase field cpu_bus[5:4]: fetch nibble select, or data phase
    localparam logic [1:0] PHASE_N0   = 2'b00;
    localparam logic [1:0] PHASE_N1   = 2'b01;
    localparam logic [1:0] PHASE_N2   = 2'b10;
    localparam logic [1:0] DATA_PHASE = 2'b11;

    typedef enum logic {
        LOADING = 1'b0,
        RUN     = 1'b1
    } ld_state_t;

endpackage

// File: rtl/nibble_regfile.sv
// Flop array with one masked synchronous write port, a synchronous clear and one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is combinational.
// Backpressure: none, writes are always accepted; clear takes priority over a same-cycle write.
module nibble_regfile #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 4,
    localparam int IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [IW-1:0]    wr_idx,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic [WIDTH-1:0] wr_mask,
    input  logic [IW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_dat
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage: async reset to zero, sync clear, otherwise masked merge into the addressed entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wr_idx] <= (mem[wr_idx] & ~wr_mask) | (wr_dat & wr_mask);
        end
    end

    // Read port: purely combinational so fetches and loads answer in the same bus cycle
    always_comb begin
        rd_dat = mem[rd_idx];
    end

endmodule

// File: rtl/nibble_bus_memory.sv
// Memory side of the 4-bit CPU nibble bus: program store with nibble-stream loader plus 16x4 zero page.
// Latency: fetch/load data combinational in the same cycle; stores and loader writes land at the next edge.
// Backpressure: ld_ready is high only while LOADING; the CPU bus has no wait states.
module nibble_bus_memory
    import nibble_bus_pkg::*;
#(
    parameter int PROG_DEPTH = 16,
    parameter int ZP_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] cpu_addr,
    input  logic [7:0] cpu_bus,
    input  logic [7:0] cpu_bus_oe,
    output logic [3:0] cpu_rd_data,
    output logic       cpu_rst_n,
    input  logic       ld_valid,
    output logic       ld_ready,
    input  logic [3:0] ld_data,
    input  logic       ld_last,
    input  logic       ld_restart,
    output logic       ld_done
);

    localparam int AW = $clog2(PROG_DEPTH);

    // ---------------- bus decode ----------------
    logic [3:0]  code;
    logic [1:0]  phase;
    logic        is_fetch;
    logic        is_load;
    logic        is_store;
    logic        zp_hit;
    logic [9:0]  pc;
    logic        unused_ok;

    assign code      = cpu_bus[7:4];
    assign phase     = code[1:0];
    assign is_fetch  = (phase != DATA_PHASE);
    assign is_load   = (code == CODE_LOAD);
    assign is_store  = (code == CODE_STORE) && (cpu_bus_oe[3:0] == 4'hF);
    assign zp_hit    = (cpu_addr[7:4] == 4'h0);
    assign pc        = {cpu_addr, code[3:2]};
    // pc bits above the store depth wrap away; upper oe bits carry nothing for us
    assign unused_ok = ^{cpu_bus_oe[7:4], pc};

    // ---------------- loader FSM ----------------
    ld_state_t      state_q, state_d;
    logic [AW-1:0]  idx_q, idx_d;
    logic [1:0]     sub_q, sub_d;
    logic           cpu_rst_q;
    logic           prog_we;
    logic           zp_clr;
    logic [11:0]    prog_mask;
    logic [11:0]    prog_rd;
    logic [3:0]     zp_rd;

    // State and load pointer registers; cpu_rst_n drops on the same edge as a restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOADING;
            idx_q     <= '0;
            sub_q     <= '0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sub_q     <= sub_d;
            cpu_rst_q <= (state_q == RUN) && !ld_restart;
        end
    end

    // Next state: step the nibble pointer on each accepted transfer, leave on last or full store
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sub_d   = sub_q;
        prog_we = 1'b0;
        zp_clr  = 1'b0;
        case (state_q)
            LOADING: begin
                if (ld_valid) begin
                    prog_we = 1'b1;
                    if (ld_last || ((idx_q == AW'(PROG_DEPTH - 1)) && (sub_q == 2'd2))) begin
                        state_d = RUN;
                    end
                    if (sub_q == 2'd2) begin
                        sub_d = 2'd0;
                        idx_d = idx_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            RUN: begin
                if (ld_restart) begin
                    state_d = LOADING;
                    idx_d   = '0;
                    sub_d   = '0;
                    zp_clr  = 1'b1;
                end
            end
            default: state_d = LOADING;
        endcase
    end

    // Nibble lane enable for the loader write: n0 in the low nibble, n2 in the high
    always_comb begin
        case (sub_q)
            2'd0:    prog_mask = 12'h00F;
            2'd1:    prog_mask = 12'h0F0;
            default: prog_mask = 12'hF00;
        endcase
    end

    assign ld_ready  = (state_q == LOADING);
    assign ld_done   = (state_q == RUN);
    assign cpu_rst_n = cpu_rst_q;

    // ---------------- storage ----------------
    nibble_regfile #(.DEPTH(PROG_DEPTH), .WIDTH(12)) u_prog (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (1'b0),
        .wr_en   (prog_we),
        .wr_idx  (idx_q),
        .wr_dat  ({3{ld_data}}),
        .wr_mask (prog_mask),
        .rd_idx  (pc[AW-1:0]),
        .rd_dat  (prog_rd)
    );

    nibble_regfile #(.DEPTH(ZP_DEPTH), .WIDTH(4)) u_zp (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (zp_clr),
        .wr_en   (is_store && zp_hit),
        .wr_idx  (cpu_addr[3:0]),
        .wr_dat  (cpu_bus[3:0]),
        .wr_mask (4'hF),
        .rd_idx  (cpu_addr[3:0]),
        .rd_dat  (zp_rd)
    );

    // Read data mux: instruction nibble on fetch, zero-page nibble on an in-range load, else 0
    always_comb begin
        cpu_rd_data = 4'h0;
        if (is_fetch) begin
            case (phase)
                PHASE_N0: cpu_rd_data = prog_rd[3:0];
                PHASE_N1: cpu_rd_data = prog_rd[7:4];
                default:  cpu_rd_data = prog_rd[11:8];
            endcase
        end else if (is_load && zp_hit) begin
            cpu_rd_data = zp_rd;
        end
    end

endmodule

// File: tb/tb_nibble_bus_memory.sv
// Bench for nibble_bus_memory: directed scenarios plus random traffic against a nibble-array model.
// Latency: checks combinational read data mid-cycle, registered outputs after each edge.
// Backpressure: loader transfers only counted by the model while it is in LOADING.
module tb_nibble_bus_memory;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] cpu_addr, cpu_bus, cpu_bus_oe;
    logic [3:0] cpu_rd_data;
    logic       cpu_rst_n;
    logic       ld_valid, ld_ready, ld_last, ld_restart, ld_done;
    logic [3:0] ld_data;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    nibble_bus_memory #(.PROG_DEPTH(16), .ZP_DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_bus(cpu_bus),
        .cpu_bus_oe(cpu_bus_oe), .cpu_rd_data(cpu_rd_data), .cpu_rst_n(cpu_rst_n),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data), .ld_last(ld_last),
        .ld_restart(ld_restart), .ld_done(ld_done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Program as a flat stream of 48 nibbles, exactly as the loader sends them
    logic [3:0] nib_m [48];
    logic [3:0] zp_m  [16];
    int         ptr_m;
    bit         run_m;
    bit         crst_m;

    task automatic model_reset();
        for (int i = 0; i < 48; i++) nib_m[i] = 4'h0;
        for (int i = 0; i < 16; i++) zp_m[i] = 4'h0;
        ptr_m  = 0;
        run_m  = 1'b0;
        crst_m = 1'b0;
    endtask

    function automatic logic [3:0] exp_rd(logic [7:0] a, logic [7:0] b);
        logic [3:0] c;
        int pcv;
        c = b[7:4];
        if (c[1:0] != 2'b11) begin
            pcv = int'(a) * 4 + int'(c[3:2]);
            return nib_m[(pcv % 16) * 3 + int'(c[1:0])];
        end
        if (c == 4'b0111) return (a < 8'd16) ? zp_m[a[3:0]] : 4'h0;
        return 4'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            if (cpu_bus[7:4] == 4'b0011 && cpu_bus_oe[3:0] == 4'hF && cpu_addr < 8'd16)
                zp_m[cpu_addr[3:0]] = cpu_bus[3:0];
            crst_m = run_m && !ld_restart;
            if (run_m) begin
                if (ld_restart) begin
                    run_m = 1'b0;
                    ptr_m = 0;
                    for (int i = 0; i < 16; i++) zp_m[i] = 4'h0;
                end
            end else if (ld_valid) begin
                nib_m[ptr_m] = ld_data;
                if (ld_last || ptr_m == 47) run_m = 1'b1;
                ptr_m = ptr_m + 1;
            end
        end
    end

    task automatic chk(string nm, logic [3:0] act, logic [3:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Every cycle, mid-way between edges, all outputs against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("rd_data", cpu_rd_data, exp_rd(cpu_addr, cpu_bus));
            chk("cpu_rst_n", {3'b0, cpu_rst_n}, {3'b0, crst_m});
            chk("ld_ready", {3'b0, ld_ready}, {3'b0, !run_m});
            chk("ld_done", {3'b0, ld_done}, {3'b0, run_m});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(logic [7:0] a, logic [7:0] b, logic [7:0] oe);
        cpu_addr = a; cpu_bus = b; cpu_bus_oe = oe;
    endtask

    task automatic ldp(logic v, logic [3:0] d, logic l, logic r);
        ld_valid = v; ld_data = d; ld_last = l; ld_restart = r;
    endtask

    task automatic load_nib(logic [3:0] d, logic l);
        ldp(1'b1, d, l, 1'b0);
        tick();
        ldp(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    task automatic restart();
        ldp(1'b0, 4'h0, 1'b0, 1'b1);
        tick();
        ldp(1'b0, 4'h0, 1'b0, 1'b0);
    endtask

    // Fetch of instruction p, nibble ph
    task automatic fetch(int p, int ph);
        logic [9:0] pv;
        logic [1:0] phv;
        pv  = 10'(p);
        phv = 2'(ph);
        bus(pv[9:2], {pv[1:0], phv, 4'h0}, 8'h00);
    endtask

    task automatic look(string nm, logic [3:0] exp);
        @(negedge clk);
        chk(nm, cpu_rd_data, exp);
    endtask

    task automatic rand_bus();
        logic [7:0] a, b, oe;
        int k;
        a  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 31));
        b  = 8'($urandom);
        k  = $urandom_range(0, 3);
        if (k == 1) b[7:4] = 4'b0111;
        if (k == 2) b[7:4] = 4'b0011;
        case ($urandom_range(0, 3))
            0: oe = 8'hF0;
            1: oe = 8'h0F;
            default: oe = 8'hFF;
        endcase
        bus(a, b, oe);
    endtask

    logic [3:0] full_dat [48];

    initial begin
        rst_n = 1'b0;
        bus(8'h00, 8'hF0, 8'h00);
        ldp(1'b0, 4'h0, 1'b0, 1'b0);
        #3;
        chk("reset cpu_rst_n", {3'b0, cpu_rst_n}, 4'h0);
        chk("reset ld_ready", {3'b0, ld_ready}, 4'h1);
        chk("reset ld_done", {3'b0, ld_done}, 4'h0);
        #4 rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // 1: six nibbles, early end
        for (int i = 1; i <= 6; i++) load_nib(4'(i), i == 6);
        @(negedge clk);
        chk("t1 ld_done", {3'b0, ld_done}, 4'h1);
        chk("t1 cpu_rst_n first RUN cycle", {3'b0, cpu_rst_n}, 4'h0);
        tick();
        @(negedge clk);
        chk("t1 cpu_rst_n", {3'b0, cpu_rst_n}, 4'h1);
        tick();
        fetch(1, 1); look("t1 pc1 n1", 4'h5); tick();
        fetch(0, 2); look("t1 pc0 n2", 4'h3); tick();

        // 2: store then load
        bus(8'h05, 8'h3A, 8'hFF); tick();
        bus(8'h05, 8'h70, 8'h00); look("t2 load 5", 4'hA); tick();
        bus(8'h06, 8'h70, 8'h00); look("t2 load 6", 4'h0); tick();

        // 3: stores that must be ignored
        bus(8'h05, 8'h37, 8'hF0); tick();
        bus(8'h15, 8'h3C, 8'hFF); tick();
        bus(8'h05, 8'h70, 8'h00); look("t3 load 5", 4'hA); tick();
        bus(8'h15, 8'h70, 8'h00); look("t3 load 15", 4'h0); tick();

        // 4: full 48-nibble load, no ld_last, with random bus traffic
        restart();
        for (int i = 0; i < 48; i++) begin
            full_dat[i] = 4'($urandom);
            rand_bus();
            load_nib(full_dat[i], 1'b0);
        end
        @(negedge clk);
        chk("t4 ld_done", {3'b0, ld_done}, 4'h1);
        tick();
        fetch(16, 0); look("t4 wrap pc010 n0", full_dat[0]); tick();
        fetch(7, 2); look("t4 pc7 n2", full_dat[23]); tick();
        for (int i = 0; i < 4; i++) begin
            ldp(1'b1, 4'($urandom), 1'b0, 1'b0);
            fetch(i, 0);
            tick();
        end
        ldp(1'b0, 4'h0, 1'b0, 1'b0);
        fetch(0, 1); look("t4 no write in RUN", full_dat[1]); tick();

        // 5: restart clears zp, reload keeps the tail of the program
        bus(8'h03, 8'h39, 8'hFF); tick();
        bus(8'h03, 8'h70, 8'h00); look("t5 zp3 before", 4'h9); tick();
        restart();
        @(negedge clk);
        chk("t5 cpu_rst_n", {3'b0, cpu_rst_n}, 4'h0);
        chk("t5 ld_ready", {3'b0, ld_ready}, 4'h1);
        chk("t5 zp3 cleared", cpu_rd_data, 4'h0);
        tick();
        load_nib(4'hA, 1'b0); load_nib(4'hB, 1'b0); load_nib(4'hC, 1'b1);
        fetch(0, 2); look("t5 pc0 n2 new", 4'hC); tick();
        fetch(1, 0); look("t5 pc1 kept", full_dat[3]); tick();
        fetch(15, 2); look("t5 pc15 kept", full_dat[47]); tick();

        // 6: async reset mid-load at ptr 7
        restart();
        for (int i = 1; i <= 7; i++) load_nib(4'(i), 1'b0);
        fetch(1, 0); look("t6 pc1 before reset", 4'h4);
        #2 rst_n = 1'b0;
        #1;
        chk("t6 cpu_rst_n", {3'b0, cpu_rst_n}, 4'h0);
        chk("t6 ld_ready", {3'b0, ld_ready}, 4'h1);
        chk("t6 pc1 after reset", cpu_rd_data, 4'h0);
        tick();
        #2 rst_n = 1'b1;
        for (int p = 0; p < 16; p++) begin
            for (int ph = 0; ph < 3; ph++) begin
                fetch(p, ph);
                #0.1;
                chk("t6 prog zero", cpu_rd_data, 4'h0);
            end
        end
        tick();
        load_nib(4'h9, 1'b0);
        fetch(0, 0); look("t6 ptr restarted", 4'h9); tick();

        // Random traffic on both bus and loader
        for (int n = 0; n < 600; n++) begin
            rand_bus();
            ldp(($urandom_range(0, 1) == 1), 4'($urandom),
                ($urandom_range(0, 15) == 0), ($urandom_range(0, 39) == 0));
            tick();
        end
        ldp(1'b0, 4'h0, 1'b0, 1'b0);
        tick();
        chk_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
